// File: rtl/sram_mem_controller_if.sv
// -----------------------------------------------------------------------------
// sram_mem_controller_if
// Bundles the Mem-stage request bus and the board SRAM pins of the
// data-memory controller into one interface.
//
// Signals:
//   rd_en, wr_en   level requests from the Mem stage, held until ready
//   address        CPU byte address
//   write_data     store data
//   read_data      registered load result
//   ready          low while a transaction is in flight (pipeline freeze)
//   sram_addr      SRAM half-word address
//   sram_dq_out    SRAM write data
//   sram_dq_in     SRAM read data
//   sram_dq_oe     drive enable for the top-level tristate on the data bus
//   sram_we_n      SRAM write strobe, active low
//
// Modports:
//   master  request side (Mem stage) together with the SRAM device
//   slave   the controller itself
// -----------------------------------------------------------------------------
interface sram_mem_controller_if #(
   parameter int WORD_WIDTH      = 32,
   parameter int SRAM_DATA_WIDTH = WORD_WIDTH / 2,
   parameter int SRAM_ADDR_WIDTH = 18
);

   logic                       rd_en;
   logic                       wr_en;
   logic [WORD_WIDTH-1:0]      address;
   logic [WORD_WIDTH-1:0]      write_data;
   logic [WORD_WIDTH-1:0]      read_data;
   logic                       ready;
   logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
   logic [SRAM_DATA_WIDTH-1:0] sram_dq_out;
   logic [SRAM_DATA_WIDTH-1:0] sram_dq_in;
   logic                       sram_dq_oe;
   logic                       sram_we_n;

   modport master (
      output rd_en,
      output wr_en,
      output address,
      output write_data,
      output sram_dq_in,
      input  read_data,
      input  ready,
      input  sram_addr,
      input  sram_dq_out,
      input  sram_dq_oe,
      input  sram_we_n
   );

   modport slave (
      input  rd_en,
      input  wr_en,
      input  address,
      input  write_data,
      input  sram_dq_in,
      output read_data,
      output ready,
      output sram_addr,
      output sram_dq_out,
      output sram_dq_oe,
      output sram_we_n
   );

endinterface

// File: rtl/sram_mem_controller.sv
// -----------------------------------------------------------------------------
// sram_mem_controller
// Sequences each 32-bit data-memory access from the Mem stage onto a 16-bit
// asynchronous SRAM as two half-word phases (low half first). Each phase is
// held for WAIT_CYCLES clocks; ready stays low until the DONE clock so the
// pipeline freezes for the whole transaction.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   sram_mem_controller_if.slave: Mem-stage request/response signals
//         and the SRAM address/data/strobe pins
// -----------------------------------------------------------------------------
module sram_mem_controller #(
   parameter int          WORD_WIDTH      = 32,
   parameter int          SRAM_DATA_WIDTH = WORD_WIDTH / 2,
   parameter int          SRAM_ADDR_WIDTH = 18,
   parameter int unsigned MEM_BASE        = 1024,
   parameter int          WAIT_CYCLES     = 2
) (
   input logic                  clk,
   input logic                  rst,
   sram_mem_controller_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH,
      DONE
   } state_t;

   localparam int                   CNT_WIDTH = $clog2(WAIT_CYCLES);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(WAIT_CYCLES - 1);

   state_t                     state;
   state_t                     state_next;
   logic [CNT_WIDTH-1:0]       cnt;
   logic [CNT_WIDTH-1:0]       cnt_next;

   logic                       op_write;
   logic [SRAM_ADDR_WIDTH-2:0] word_addr;
   logic [WORD_WIDTH-1:0]      data_latched;
   logic [WORD_WIDTH-1:0]      read_data_reg;

   logic [WORD_WIDTH-1:0]      offset;
   logic                       start;
   logic                       last_cycle;
   logic                       half;
   logic                       unused_offset_bits;

   logic                       ready_c;
   logic [SRAM_ADDR_WIDTH-1:0] sram_addr_c;
   logic [SRAM_DATA_WIDTH-1:0] sram_dq_out_c;
   logic                       sram_dq_oe_c;
   logic                       sram_we_n_c;

   // Byte offset from the SRAM window base; addresses below the base simply
   // wrap around the half-word space. Byte-lane bits and the bits above the
   // SRAM word range are dropped.
   assign offset             = bus.address - WORD_WIDTH'(MEM_BASE);
   assign unused_offset_bits = ^{offset[WORD_WIDTH-1:SRAM_ADDR_WIDTH+1], offset[1:0]};

   assign start      = (state == IDLE) & (bus.rd_en | bus.wr_en);
   assign last_cycle = (cnt == CNT_LAST);
   assign half       = (state == HIGH);

   // State and wait-counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic: each half-word phase lasts WAIT_CYCLES clocks, and the
   // DONE clock is the single cycle on which the pipeline is allowed to move.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (start) begin
               state_next = LOW;
            end
         end
         LOW: begin
            if (last_cycle) begin
               state_next = HIGH;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         HIGH: begin
            if (last_cycle) begin
               state_next = DONE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Request capture: once a transaction starts, the Mem-stage inputs are no
   // longer looked at, so late changes or deassertion cannot abort it.
   // A simultaneous read and write is treated as a write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_write     <= 1'b0;
         word_addr    <= '0;
         data_latched <= '0;
      end else if (start) begin
         op_write     <= bus.wr_en;
         word_addr    <= offset[SRAM_ADDR_WIDTH:2];
         data_latched <= bus.write_data;
      end
   end

   // Read capture: each half is sampled on the last cycle of its phase, when
   // the asynchronous SRAM has had the full wait time to settle. Writes leave
   // the previous load result untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read_data_reg <= '0;
      end else if (!op_write && last_cycle) begin
         if (state == LOW) begin
            read_data_reg[SRAM_DATA_WIDTH-1:0] <= bus.sram_dq_in;
         end else if (state == HIGH) begin
            read_data_reg[WORD_WIDTH-1:SRAM_DATA_WIDTH] <= bus.sram_dq_in;
         end
      end
   end

   // Output decode. The write strobe is released on the last cycle of each
   // phase so address and data are still stable when we_n rises.
   always_comb begin
      ready_c       = 1'b0;
      sram_addr_c   = '0;
      sram_dq_out_c = '0;
      sram_dq_oe_c  = 1'b0;
      sram_we_n_c   = 1'b1;
      case (state)
         IDLE: begin
            ready_c = ~bus.rd_en & ~bus.wr_en;
         end
         LOW, HIGH: begin
            sram_addr_c = {word_addr, half};
            if (op_write) begin
               sram_dq_oe_c  = 1'b1;
               sram_we_n_c   = last_cycle;
               sram_dq_out_c = half ? data_latched[WORD_WIDTH-1:SRAM_DATA_WIDTH]
                                    : data_latched[SRAM_DATA_WIDTH-1:0];
            end
         end
         DONE: begin
            ready_c = 1'b1;
         end
         default: begin
            ready_c = 1'b0;
         end
      endcase
   end

   assign bus.ready       = ready_c;
   assign bus.read_data   = read_data_reg;
   assign bus.sram_addr   = sram_addr_c;
   assign bus.sram_dq_out = sram_dq_out_c;
   assign bus.sram_dq_oe  = sram_dq_oe_c;
   assign bus.sram_we_n   = sram_we_n_c;

endmodule

// File: tb/tb_sram_mem_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_mem_controller
// Self-checking bench for sram_mem_controller. A simple asynchronous SRAM
// device sits on the pins, a transaction-level reference model predicts every
// output on every cycle, and a set of directed transactions pin the model with
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_sram_mem_controller;

   localparam int          WW    = 32;
   localparam int          DW    = 16;
   localparam int          AW    = 18;
   localparam int unsigned BASE  = 1024;
   localparam int          WAIT  = 2;
   localparam int          SPAN  = 2 * WAIT;

   logic clk;
   logic rst;

   int checks;
   int errors;

   sram_mem_controller_if #(
      .WORD_WIDTH     (WW),
      .SRAM_DATA_WIDTH(DW),
      .SRAM_ADDR_WIDTH(AW)
   ) bus ();

   sram_mem_controller #(
      .WORD_WIDTH     (WW),
      .SRAM_DATA_WIDTH(DW),
      .SRAM_ADDR_WIDTH(AW),
      .MEM_BASE       (BASE),
      .WAIT_CYCLES    (WAIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Generic comparison used by every check in the bench.
   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Contents an untouched SRAM location reports.
   function automatic logic [15:0] blank_value(input logic [17:0] a);
      return a[15:0] ^ 16'h5A5A;
   endfunction

   // ---------------- SRAM device on the pins ----------------
   logic [15:0] dev_mem [logic [17:0]];

   function automatic logic [15:0] dev_read(input logic [17:0] a);
      if (dev_mem.exists(a)) return dev_mem[a];
      return blank_value(a);
   endfunction

   always @(negedge clk) begin
      if (!rst && !bus.sram_we_n && bus.sram_dq_oe) begin
         dev_mem[bus.sram_addr] = bus.sram_dq_out;
      end
      bus.sram_dq_in = dev_read(bus.sram_addr);
   end

   // ---------------- transaction-level reference model ----------------
   logic [15:0] ref_mem [logic [17:0]];

   function automatic logic [15:0] ref_read(input logic [17:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return blank_value(a);
   endfunction

   bit          m_busy;
   int          m_k;
   bit          m_write;
   int unsigned m_word;
   logic [31:0] m_data;
   logic [31:0] m_rd;

   // Each request is a fixed timeline of SPAN+2 clocks: the request clock in
   // IDLE, SPAN clocks of half-word phases, then the single ready clock.
   always @(negedge clk) begin
      int   phase;
      int   pos;
      logic [31:0] exp_addr;
      if (rst) begin
         m_busy = 0;
         m_rd   = 32'h0;
         check_output("rst_ready", 32'(bus.ready), 32'(!(bus.rd_en || bus.wr_en)));
         check_output("rst_we_n", 32'(bus.sram_we_n), 32'd1);
         check_output("rst_oe", 32'(bus.sram_dq_oe), 32'd0);
         check_output("rst_addr", 32'(bus.sram_addr), 32'd0);
         check_output("rst_dq_out", 32'(bus.sram_dq_out), 32'd0);
         check_output("rst_read_data", bus.read_data, 32'd0);
      end else begin
         if (!m_busy && (bus.rd_en || bus.wr_en)) begin
            m_busy  = 1;
            m_k     = 0;
            m_write = bus.wr_en;
            m_word  = ((bus.address - BASE) / 4) % (1 << (AW - 1));
            m_data  = bus.write_data;
         end
         if (!m_busy) begin
            check_output("idle_ready", 32'(bus.ready), 32'd1);
            check_output("idle_oe", 32'(bus.sram_dq_oe), 32'd0);
            check_output("idle_we_n", 32'(bus.sram_we_n), 32'd1);
            check_output("idle_read_data", bus.read_data, m_rd);
         end else if (m_k == 0) begin
            check_output("req_ready", 32'(bus.ready), 32'd0);
            check_output("req_oe", 32'(bus.sram_dq_oe), 32'd0);
            check_output("req_we_n", 32'(bus.sram_we_n), 32'd1);
            check_output("req_read_data", bus.read_data, m_rd);
         end else if (m_k <= SPAN) begin
            phase    = (m_k - 1) / WAIT;
            pos      = (m_k - 1) % WAIT;
            exp_addr = 32'(m_word * 2 + phase);
            check_output("phase_ready", 32'(bus.ready), 32'd0);
            check_output("phase_addr", 32'(bus.sram_addr), exp_addr);
            if (m_write) begin
               check_output("wr_oe", 32'(bus.sram_dq_oe), 32'd1);
               check_output("wr_we_n", 32'(bus.sram_we_n), 32'(pos == WAIT - 1));
               check_output("wr_dq_out", 32'(bus.sram_dq_out),
                            phase == 0 ? 32'(m_data[15:0]) : 32'(m_data[31:16]));
               check_output("wr_read_data", bus.read_data, m_rd);
            end else begin
               check_output("rd_oe", 32'(bus.sram_dq_oe), 32'd0);
               check_output("rd_we_n", 32'(bus.sram_we_n), 32'd1);
            end
         end else begin
            if (m_write) begin
               ref_mem[18'(m_word * 2)]     = m_data[15:0];
               ref_mem[18'(m_word * 2 + 1)] = m_data[31:16];
            end else begin
               m_rd = {ref_read(18'(m_word * 2 + 1)), ref_read(18'(m_word * 2))};
            end
            check_output("done_ready", 32'(bus.ready), 32'd1);
            check_output("done_oe", 32'(bus.sram_dq_oe), 32'd0);
            check_output("done_we_n", 32'(bus.sram_we_n), 32'd1);
            check_output("done_read_data", bus.read_data, m_rd);
         end
         if (m_busy) begin
            m_k++;
            if (m_k > SPAN + 1) m_busy = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   // Presents one request and waits for ready. Reports the number of stalled
   // clocks, the SRAM address of the first and last phase cycles and the
   // we_n sequence over the phase cycles (oldest in the highest bit).
   task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] d, input bit drop,
                                 output int low_cnt, output logic [17:0] lo_a,
                                 output logic [17:0] hi_a, output logic [7:0] we_hist);
      bit got;
      @(posedge clk);
      #1;
      bus.rd_en      = rd;
      bus.wr_en      = wr;
      bus.address    = a;
      bus.write_data = d;
      low_cnt = 0;
      lo_a    = '0;
      hi_a    = '0;
      we_hist = '0;
      got     = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (i == 1) lo_a = bus.sram_addr;
         if (i == SPAN) hi_a = bus.sram_addr;
         if (i >= 1 && i <= SPAN) we_hist = {we_hist[6:0], bus.sram_we_n};
         if (bus.ready) got = 1;
         else low_cnt++;
         if (drop && i == 1) begin
            #2;
            bus.rd_en = 1'b0;
            bus.wr_en = 1'b0;
         end
      end
      if (!got) check_output("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic go_idle();
      @(posedge clk);
      #1;
      bus.rd_en      = 1'b0;
      bus.wr_en      = 1'b0;
      bus.address    = '0;
      bus.write_data = '0;
   endtask

   int          lc;
   logic [17:0] la;
   logic [17:0] ha;
   logic [7:0]  wh;

   initial begin
      checks = 0;
      errors = 0;
      m_busy = 0;
      m_k    = 0;
      m_rd   = 32'h0;
      rst            = 1'b1;
      bus.rd_en      = 1'b0;
      bus.wr_en      = 1'b0;
      bus.address    = '0;
      bus.write_data = '0;
      bus.sram_dq_in = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset with no request.
      @(negedge clk);
      check_output("reset_ready", 32'(bus.ready), 32'd1);
      check_output("reset_we_n", 32'(bus.sram_we_n), 32'd1);
      check_output("reset_oe", 32'(bus.sram_dq_oe), 32'd0);
      check_output("reset_read_data", bus.read_data, 32'd0);

      // Write 0xDEADBEEF at byte 1028 -> half-words 2 and 3.
      apply_stimulus(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 0, lc, la, ha, wh);
      check_output("wr_stall", 32'(lc), 32'd5);
      check_output("wr_lo_addr", 32'(la), 32'd2);
      check_output("wr_hi_addr", 32'(ha), 32'd3);
      check_output("wr_we_pattern", 32'(wh), 32'h05);
      check_output("wr_sram_lo", 32'(dev_read(18'd2)), 32'h0000BEEF);
      check_output("wr_sram_hi", 32'(dev_read(18'd3)), 32'h0000DEAD);
      go_idle();

      // Read it back.
      apply_stimulus(1'b1, 1'b0, 32'd1028, 32'h0, 0, lc, la, ha, wh);
      check_output("rd_data", bus.read_data, 32'hDEADBEEF);
      check_output("rd_stall", 32'(lc), 32'd5);
      go_idle();

      // Read and write together: the write wins, read_data is untouched.
      apply_stimulus(1'b1, 1'b1, 32'd1024, 32'h12345678, 0, lc, la, ha, wh);
      check_output("both_we_pattern", 32'(wh), 32'h05);
      check_output("both_sram_lo", 32'(dev_read(18'd0)), 32'h00005678);
      check_output("both_sram_hi", 32'(dev_read(18'd1)), 32'h00001234);
      check_output("both_read_data", bus.read_data, 32'hDEADBEEF);
      go_idle();

      // wr_en dropped during LOW: the transaction still finishes.
      apply_stimulus(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 1, lc, la, ha, wh);
      check_output("drop_stall", 32'(lc), 32'd5);
      check_output("drop_sram_hi", 32'(dev_read(18'd5)), 32'h0000CAFE);
      go_idle();

      // Address below the base wraps to the top SRAM word.
      apply_stimulus(1'b1, 1'b0, 32'd1020, 32'h0, 0, lc, la, ha, wh);
      check_output("wrap_lo_addr", 32'(la), 32'h3FFFE);
      check_output("wrap_hi_addr", 32'(ha), 32'h3FFFF);
      check_output("wrap_read_data", bus.read_data, 32'hA5A5A5A4);
      go_idle();

      // Back-to-back: write then read with a single IDLE clock between.
      apply_stimulus(1'b0, 1'b1, 32'd1040, 32'h0BADC0DE, 0, lc, la, ha, wh);
      apply_stimulus(1'b1, 1'b0, 32'd1040, 32'h0, 0, lc, la, ha, wh);
      check_output("b2b_stall", 32'(lc), 32'd5);
      check_output("b2b_read_data", bus.read_data, 32'h0BADC0DE);
      go_idle();

      // Reset asserted during the HIGH phase of a read.
      @(posedge clk);
      #1;
      bus.rd_en   = 1'b1;
      bus.address = 32'd1028;
      repeat (3) @(posedge clk);
      #1;
      rst       = 1'b1;
      bus.rd_en = 1'b0;
      #1;
      check_output("midrst_ready", 32'(bus.ready), 32'd1);
      check_output("midrst_we_n", 32'(bus.sram_we_n), 32'd1);
      check_output("midrst_oe", 32'(bus.sram_dq_oe), 32'd0);
      check_output("midrst_read_data", bus.read_data, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
